// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Merges the I-cache and D-cache slow-memory ports onto one shared 128-bit
//   line memory. A single transaction is in flight at a time: the winner's
//   command is registered onto the memory bus, the returned line is captured
//   into that side's rdata register, and that side gets a one-cycle ready
//   pulse. Ties alternate, starting with D after reset.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   read_I/write_I/addr_I/wdata_I   I-side request, held until ready_I
//   rdata_I, ready_I           I-side returned line and completion pulse
//   read_D ... ready_D         same handshake for the D side
//   mem_read/mem_write/mem_addr/mem_wdata   registered shared-memory command
//   mem_rdata, mem_ready       shared-memory returned line and completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_I,
    input  logic              write_I,
    input  logic [ADDR_W-1:0] addr_I,
    input  logic [LINE_W-1:0] wdata_I,
    output logic [LINE_W-1:0] rdata_I,
    output logic              ready_I,
    input  logic              read_D,
    input  logic              write_D,
    input  logic [ADDR_W-1:0] addr_D,
    input  logic [LINE_W-1:0] wdata_D,
    output logic [LINE_W-1:0] rdata_D,
    output logic              ready_D,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;
    typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

    state_t            r_state;
    state_t            w_state_next;
    side_t             r_last_grant;
    side_t             r_grant;
    side_t             w_grant_side;
    logic              w_grant;
    logic              w_req_I;
    logic              w_req_D;
    logic              w_sel_read;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LINE_W-1:0] w_sel_wdata;

    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_rdata_I;
    logic [LINE_W-1:0] r_rdata_D;
    logic              r_ready_I;
    logic              r_ready_D;

    assign w_req_I = read_I | write_I;
    assign w_req_D = read_D | write_D;

    // Next-state and grant decision.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_side = SIDE_I;
        case (r_state)
            IDLE: begin
                if (w_req_I || w_req_D) begin
                    w_grant      = 1'b1;
                    w_state_next = BUSY;
                    if (w_req_I && w_req_D) begin
                        // Tie: hand the bus to whoever did not win last time.
                        w_grant_side = (r_last_grant == SIDE_I) ? SIDE_D : SIDE_I;
                    end else begin
                        w_grant_side = w_req_D ? SIDE_D : SIDE_I;
                    end
                end
            end
            BUSY:    if (mem_ready) w_state_next = RESP;
            RESP:    w_state_next = GAP;
            // The dead cycle lets the client drop its request before the
            // next arbitration, so a finished request is never re-granted.
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Command fields of the side being granted this cycle.
    assign w_sel_read  = (w_grant_side == SIDE_D) ? read_D  : read_I;
    assign w_sel_write = (w_grant_side == SIDE_D) ? write_D : write_I;
    assign w_sel_addr  = (w_grant_side == SIDE_D) ? addr_D  : addr_I;
    assign w_sel_wdata = (w_grant_side == SIDE_D) ? wdata_D : wdata_I;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SIDE_I;
            r_grant      <= SIDE_I;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata_I    <= '0;
            r_rdata_D    <= '0;
            r_ready_I    <= 1'b0;
            r_ready_D    <= 1'b0;
        end else begin
            // Ready is a pulse: only the BUSY->RESP edge below raises it.
            r_ready_I <= 1'b0;
            r_ready_D <= 1'b0;

            if (w_grant) begin
                r_grant      <= w_grant_side;
                r_last_grant <= w_grant_side;
                r_mem_addr   <= w_sel_addr;
                r_mem_wdata  <= w_sel_wdata;
                // Write takes precedence when a client raises both strobes.
                r_mem_write  <= w_sel_write;
                r_mem_read   <= w_sel_read & ~w_sel_write;
            end

            if (r_state == BUSY && mem_ready) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                if (r_grant == SIDE_D) begin
                    r_rdata_D <= mem_rdata;
                    r_ready_D <= 1'b1;
                end else begin
                    r_rdata_I <= mem_rdata;
                    r_ready_I <= 1'b1;
                end
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata_I   = r_rdata_I;
    assign rdata_D   = r_rdata_D;
    assign ready_I   = r_ready_I;
    assign ready_D   = r_ready_D;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed stimulus for mem_arbiter. Each transaction pushes the expected
//   memory command and the expected client response into queues; a memory
//   model pops commands as strobes appear and a response monitor pops
//   responses whenever a ready pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          read_I = 1'b0, write_I = 1'b0;
    logic [AW-1:0] addr_I = '0;
    logic [LW-1:0] wdata_I = '0;
    logic [LW-1:0] rdata_I;
    logic          ready_I;
    logic          read_D = 1'b0, write_D = 1'b0;
    logic [AW-1:0] addr_D = '0;
    logic [LW-1:0] wdata_D = '0;
    logic [LW-1:0] rdata_D;
    logic          ready_D;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_I(read_I), .write_I(write_I), .addr_I(addr_I), .wdata_I(wdata_I),
        .rdata_I(rdata_I), .ready_I(ready_I),
        .read_D(read_D), .write_D(write_D), .addr_D(addr_D), .wdata_D(wdata_D),
        .rdata_D(rdata_D), .ready_D(ready_D),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            side;       // 0 = I, 1 = D
        bit            write;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;      // line the memory model returns
        int            lat;        // strobe cycles before mem_ready
        int            exp_start;  // exact strobe cycle, or -1
        bit            gap_exact;  // strobe must start 4 cycles after last mem_ready
    } cmd_t;

    typedef struct {
        bit            side;
        logic [LW-1:0] rdata;
        bit            chk_data;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    bit mem_auto = 1'b1;
    int last_ready_cyc = -100;
    logic [LW-1:0] last_i_line = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input bit side, input bit write, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input logic [LW-1:0] rdata,
                              input int lat, input int exp_start, input bit gap_exact);
        cmd_t  c;
        resp_t r;
        c.side = side; c.write = write; c.addr = addr; c.wdata = wdata; c.rdata = rdata;
        c.lat = lat; c.exp_start = exp_start; c.gap_exact = gap_exact;
        r.side = side; r.rdata = rdata; r.chk_data = !write;
        cmd_q.push_back(c);
        resp_q.push_back(r);
        if (!side && !write) last_i_line = rdata;
    endtask

    // Client: raise request, hold until this side's ready, then drop.
    task automatic client(input bit side, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [LW-1:0] wd);
        bit got = 1'b0;
        if (side) begin
            read_D = rd; write_D = wr; addr_D = a; wdata_D = wd;
        end else begin
            read_I = rd; write_I = wr; addr_I = a; wdata_I = wd;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (side ? ready_D : ready_I) begin
                got = 1'b1;
                break;
            end
        end
        check(side ? "client_D_timeout" : "client_I_timeout", got, 1'b1);
        if (side) begin
            read_D = 1'b0; write_D = 1'b0;
        end else begin
            read_I = 1'b0; write_I = 1'b0;
        end
    endtask

    // Memory model: checks each command against the queue and answers it.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (mem_auto && rst_n && (mem_read || mem_write)) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_mem_cmd", {mem_read, mem_write}, 2'b00);
                    @(negedge clk);
                end else begin
                    c = cmd_q.pop_front();
                    if (c.exp_start >= 0) check("strobe_latency", cyc, c.exp_start);
                    if (c.gap_exact) check("regrant_gap", cyc, last_ready_cyc + 4);
                    for (int k = 0; k < c.lat; k++) begin
                        if (k > 0) @(negedge clk);
                        check("mem_op", {mem_read, mem_write}, {!c.write, c.write});
                        check("mem_addr", mem_addr, c.addr);
                        check("mem_wdata", mem_wdata, c.wdata);
                    end
                    mem_rdata = c.rdata;
                    mem_ready = 1'b1;
                    last_ready_cyc = cyc;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    check("ready_latency", c.side ? ready_D : ready_I, 1'b1);
                    check("strobe_clear", {mem_read, mem_write}, 2'b00);
                end
            end
        end
    end

    // Response monitor: every ready pulse must match the next expected response.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (ready_I || ready_D) begin
                check("ready_exclusive", {ready_I, ready_D} == 2'b11, 1'b0);
                if (resp_q.size() == 0) begin
                    check("unexpected_ready", {ready_I, ready_D}, 2'b00);
                end else begin
                    r = resp_q.pop_front();
                    check("ready_side", {ready_I, ready_D}, r.side ? 2'b01 : 2'b10);
                    if (r.chk_data) begin
                        if (r.side) check("rdata_D", rdata_D, r.rdata);
                        else        check("rdata_I", rdata_I, r.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset_outputs", |{rdata_I, ready_I, rdata_D, ready_D,
                                 mem_read, mem_write, mem_addr, mem_wdata}, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // I read alone: strobe next cycle, 4 strobe cycles.
        expect_txn(0, 0, 28'h0000100, '0, 128'hDEADBEEF_CAFEF00D_12345678_00000001, 4, cyc + 1, 0);
        client(0, 1, 0, 28'h0000100, '0);
        check("ready_D_quiet", ready_D, 1'b0);
        settle();

        // D write alone.
        expect_txn(1, 1, 28'h0000200, {4{32'h11111111}}, 128'h0, 3, cyc + 1, 0);
        client(1, 0, 1, 28'h0000200, {4{32'h11111111}});
        settle();

        // Reset mid-transaction: no mem_ready, outputs drop at once.
        mem_auto = 1'b0;
        read_I = 1'b1; addr_I = 28'h0000ABC;
        @(negedge clk);
        check("rst_mid_strobe", {mem_read, mem_addr}, {1'b1, 28'h0000ABC});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outputs", |{rdata_I, ready_I, rdata_D, ready_D,
                                      mem_read, mem_write, mem_addr, mem_wdata}, 1'b0);
        read_I = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_auto = 1'b1;
        @(negedge clk);
        expect_txn(0, 0, 28'h0000700, '0, 128'h0707_0707_0000_0000_0000_0000_0000_0707, 2, cyc + 1, 0);
        client(0, 1, 0, 28'h0000700, '0);
        settle();

        // Simultaneous after reset: D first, I regranted 3 cycles after D's mem_ready.
        do_reset();
        expect_txn(1, 0, 28'h0000400, '0, 128'hD0D0_0000_0000_0000_0000_0000_0000_0400, 2, cyc + 1, 0);
        expect_txn(0, 0, 28'h0000300, '0, 128'h1010_0000_0000_0000_0000_0000_0000_0300, 2, -1, 1);
        fork
            client(0, 1, 0, 28'h0000300, '0);
            client(1, 1, 0, 28'h0000400, '0);
        join
        settle();

        // Fairness: D back-to-back, I arrives during the first D -> D, I, D.
        expect_txn(1, 0, 28'h0000500, '0, 128'h5555_0000_0000_0000_0000_0000_0000_0500, 3, cyc + 1, 0);
        expect_txn(0, 0, 28'h0000600, '0, 128'h6666_0000_0000_0000_0000_0000_0000_0600, 3, -1, 1);
        expect_txn(1, 0, 28'h0000501, '0, 128'h5555_0000_0000_0000_0000_0000_0000_0501, 3, -1, 1);
        fork
            begin
                client(1, 1, 0, 28'h0000500, '0);
                client(1, 1, 0, 28'h0000501, '0);
            end
            begin
                @(negedge clk);
                client(0, 1, 0, 28'h0000600, '0);
            end
        join
        settle();

        // Read and write together: write wins.
        expect_txn(1, 1, 28'h0000800, {4{32'hA5A5A5A5}}, 128'h0, 2, cyc + 1, 0);
        client(1, 1, 1, 28'h0000800, {4{32'hA5A5A5A5}});
        settle();

        // Stray mem_ready in IDLE: ignored, arbiter stays idle.
        mem_rdata = {4{32'hBADBAD00}};
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_quiet", {ready_I, ready_D, mem_read, mem_write}, 4'b0000);
        end
        check("rdata_I_hold", rdata_I, last_i_line);
        expect_txn(1, 0, 28'h0000900, '0, 128'h9999_0000_0000_0000_0000_0000_0000_0900, 1, cyc + 1, 0);
        client(1, 1, 0, 28'h0000900, '0);
        settle();

        check("rdata_I_final", rdata_I, last_i_line);
        check("cmd_q_empty", cmd_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
